// File: rtl/rd_sched.sv
// Descriptor scheduler for the packet read controller.
// Queues {control, begin, end} descriptors, launches one rd_ctrl transfer per
// descriptor when rd_ctrl is idle, and tracks completions, malformed
// descriptors and hung transfers.
module rd_sched #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     flush,
    input  logic                     desc_valid,
    output logic                     desc_ready,
    input  logic [31:0]              desc_control,
    input  logic [31:0]              desc_begin,
    input  logic [31:0]              desc_end,
    output logic                     rd_ctrl,
    output logic [31:0]              control,
    output logic [31:0]              pkt_begin,
    output logic [31:0]              pkt_end,
    input  logic                     rd_ctrl_rdy,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   desc_level,
    output logic [31:0]              pkt_count,
    output logic                     err_len,
    output logic                     err_timeout
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_LOW,
        S_WAIT_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [WW-1:0] wd_q, wd_d;
    logic [31:0]   control_q, control_d;
    logic [31:0]   pkt_begin_q, pkt_begin_d;
    logic [31:0]   pkt_end_q, pkt_end_d;
    logic          rd_ctrl_q, rd_ctrl_d;
    logic          busy_q, busy_d;
    logic [31:0]   pkt_count_q, pkt_count_d;
    logic          err_len_q, err_len_d;
    logic          err_timeout_q, err_timeout_d;

    logic [95:0]   mem_q [DEPTH];

    logic [AW:0]   level;
    logic          full;
    logic          empty;
    logic          push_req;
    logic          len_ok;
    logic          push;
    logic          pop;

    assign level      = wr_ptr_q - rd_ptr_q;
    assign full       = (level == FULL_LVL);
    assign empty      = (level == '0);
    // Gated by reset so the queue reports not-ready while held in reset.
    assign desc_ready = reset & ~full;
    assign push_req   = desc_valid & desc_ready;
    assign len_ok     = (desc_end > desc_begin);
    assign push       = push_req & len_ok & ~flush;

    assign desc_level  = level;
    assign rd_ctrl     = rd_ctrl_q;
    assign control     = control_q;
    assign pkt_begin   = pkt_begin_q;
    assign pkt_end     = pkt_end_q;
    assign busy        = busy_q;
    assign pkt_count   = pkt_count_q;
    assign err_len     = err_len_q;
    assign err_timeout = err_timeout_q;

    // Next-state logic for the queue pointers, FSM, watchdog and output registers.
    always_comb begin
        state_d       = state_q;
        wd_d          = wd_q;
        control_d     = control_q;
        pkt_begin_d   = pkt_begin_q;
        pkt_end_d     = pkt_end_q;
        rd_ctrl_d     = 1'b0;
        pkt_count_d   = pkt_count_q;
        err_len_d     = err_len_q;
        err_timeout_d = err_timeout_q;
        pop           = 1'b0;

        if (push_req && !len_ok) begin
            err_len_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (enable && !empty && rd_ctrl_rdy) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // A flush on the IDLE->LOAD edge can leave nothing to load.
                if (!empty) begin
                    {control_d, pkt_begin_d, pkt_end_d} = mem_q[rd_ptr_q[AW-1:0]];
                    pop       = 1'b1;
                    rd_ctrl_d = 1'b1;
                    state_d   = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                wd_d    = '0;
                state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                wd_d = wd_q + 1'b1;
                if (!rd_ctrl_rdy) begin
                    state_d = S_WAIT_DONE;
                end else if (wd_q == WD_LAST) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                wd_d = wd_q + 1'b1;
                if (rd_ctrl_rdy) begin
                    pkt_count_d = pkt_count_q + 32'd1;
                    state_d     = S_IDLE;
                end else if (wd_q == WD_LAST) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        end
    end

    // State, pointer and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            wd_q          <= '0;
            control_q     <= '0;
            pkt_begin_q   <= '0;
            pkt_end_q     <= '0;
            rd_ctrl_q     <= 1'b0;
            busy_q        <= 1'b0;
            pkt_count_q   <= '0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            wd_q          <= wd_d;
            control_q     <= control_d;
            pkt_begin_q   <= pkt_begin_d;
            pkt_end_q     <= pkt_end_d;
            rd_ctrl_q     <= rd_ctrl_d;
            busy_q        <= busy_d;
            pkt_count_q   <= pkt_count_d;
            err_len_q     <= err_len_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // Descriptor storage; emptiness is tracked by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {desc_control, desc_begin, desc_end};
        end
    end

endmodule

// File: tb/tb_rd_sched.sv
// Directed bench for rd_sched with a simple rd_ctrl responder model.
module tb_rd_sched;

    localparam int BUSY = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic        desc_valid = 1'b0;
    logic        desc_ready;
    logic [31:0] desc_control = '0;
    logic [31:0] desc_begin = '0;
    logic [31:0] desc_end = '0;
    logic        rd_ctrl;
    logic [31:0] control;
    logic [31:0] pkt_begin;
    logic [31:0] pkt_end;
    logic        rd_ctrl_rdy = 1'b1;
    logic        busy;
    logic [3:0]  desc_level;
    logic [31:0] pkt_count;
    logic        err_len;
    logic        err_timeout;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int npulse = 0;
    int pulse_cyc = 0;
    int cnt = 0;
    bit hang = 1'b0;
    logic [31:0] pulse_beg [64];

    rd_sched #(.DEPTH(8), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_control(desc_control), .desc_begin(desc_begin), .desc_end(desc_end),
        .rd_ctrl(rd_ctrl), .control(control), .pkt_begin(pkt_begin), .pkt_end(pkt_end),
        .rd_ctrl_rdy(rd_ctrl_rdy), .busy(busy), .desc_level(desc_level),
        .pkt_count(pkt_count), .err_len(err_len), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // rd_ctrl responder: drops ready for BUSY cycles after each start pulse.
    always @(negedge clk) begin
        if (!reset) begin
            rd_ctrl_rdy = 1'b1;
            cnt = 0;
        end else begin
            if (rd_ctrl) begin
                pulse_beg[npulse] = pkt_begin;
                pulse_cyc = cyc;
                npulse = npulse + 1;
            end
            if (rd_ctrl && !hang) begin
                rd_ctrl_rdy = 1'b0;
                cnt = BUSY;
            end else if (cnt > 0) begin
                cnt = cnt - 1;
                if (cnt == 0) rd_ctrl_rdy = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] c, input logic [31:0] b, input logic [31:0] e);
        desc_valid   = 1'b1;
        desc_control = c;
        desc_begin   = b;
        desc_end     = e;
        @(negedge clk);
        desc_valid   = 1'b0;
    endtask

    task automatic wait_pkt(input logic [31:0] target, input int budget, input string tag);
        for (int i = 0; i < budget && pkt_count !== target; i++) @(negedge clk);
        chk(tag, pkt_count, target);
    endtask

    initial begin
        int t0;
        int n0;

        // Reset state
        #1;
        chk("rst_ready", 32'(desc_ready), 32'd0);
        chk("rst_count", pkt_count, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_level", 32'(desc_level), 32'd0);
        chk("rst_rdctrl", 32'(rd_ctrl), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_ready", 32'(desc_ready), 32'd1);

        // 1: single descriptor, pulse two edges after acceptance
        enable = 1'b1;
        t0 = cyc;
        push(32'd0, 32'h0, 32'h100);
        wait_pkt(32'd1, 60, "t1_count");
        chk("t1_pulses", 32'(npulse), 32'd1);
        chk("t1_latency", 32'(pulse_cyc), 32'(t0 + 3));
        chk("t1_begin", pkt_begin, 32'h0);
        chk("t1_end", pkt_end, 32'h100);
        @(negedge clk);
        chk("t1_busy", 32'(busy), 32'd0);

        // 2: fill queue with enable low, refuse 9th, drain in order
        enable = 1'b0;
        for (int i = 0; i < 8; i++)
            push(32'(i), 32'h1000 + 32'(i) * 32'h100, 32'h1040 + 32'(i) * 32'h100);
        chk("t2_level_full", 32'(desc_level), 32'd8);
        chk("t2_ready_full", 32'(desc_ready), 32'd0);
        push(32'd9, 32'h9000, 32'h9040);
        chk("t2_level_refused", 32'(desc_level), 32'd8);
        enable = 1'b1;
        wait_pkt(32'd9, 400, "t2_count");
        repeat (5) @(negedge clk);
        chk("t2_pulses", 32'(npulse), 32'd9);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t2_order%0d", i), pulse_beg[1 + i], 32'h1000 + 32'(i) * 32'h100);
        chk("t2_level_empty", 32'(desc_level), 32'd0);

        // 3: zero-length descriptor dropped, next valid one still runs
        chk("t3_err_pre", 32'(err_len), 32'd0);
        push(32'd0, 32'h200, 32'h200);
        chk("t3_err_len", 32'(err_len), 32'd1);
        chk("t3_level", 32'(desc_level), 32'd0);
        chk("t3_busy", 32'(busy), 32'd0);
        push(32'd0, 32'h300, 32'h380);
        wait_pkt(32'd10, 60, "t3_count");
        chk("t3_begin", pulse_beg[9], 32'h300);

        // 4: rd_ctrl never goes busy, watchdog aborts after 16 cycles
        chk("t4_to_pre", 32'(err_timeout), 32'd0);
        hang = 1'b1;
        push(32'd0, 32'h400, 32'h480);
        push(32'd0, 32'h500, 32'h580);
        for (int i = 0; i < 60 && err_timeout !== 1'b1; i++) @(negedge clk);
        chk("t4_timeout", 32'(err_timeout), 32'd1);
        chk("t4_wait_cycles", 32'(cyc - pulse_cyc), 32'd17);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_count", pkt_count, 32'd10);
        hang = 1'b0;
        wait_pkt(32'd11, 60, "t4_next_count");
        chk("t4_next_begin", pulse_beg[11], 32'h500);

        // 5: flush while a transfer is in flight
        push(32'd0, 32'h600, 32'h680);
        push(32'd0, 32'h700, 32'h780);
        push(32'd0, 32'h800, 32'h880);
        push(32'd0, 32'h900, 32'h980);
        chk("t5_level3", 32'(desc_level), 32'd3);
        chk("t5_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t5_flushed", 32'(desc_level), 32'd0);
        wait_pkt(32'd12, 60, "t5_count");
        repeat (20) @(negedge clk);
        chk("t5_pulses", 32'(npulse), 32'd13);
        chk("t5_begin", pulse_beg[12], 32'h600);
        chk("t5_count_final", pkt_count, 32'd12);
        chk("t5_idle", 32'(busy), 32'd0);

        // 6: async reset in WAIT_DONE, then fresh operation
        push(32'd0, 32'hA00, 32'hA80);
        for (int i = 0; i < 20 && npulse < 14; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("t6_inflight", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("t6_rst_count", pkt_count, 32'd0);
        chk("t6_rst_errlen", 32'(err_len), 32'd0);
        chk("t6_rst_errto", 32'(err_timeout), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_ready", 32'(desc_ready), 32'd0);
        chk("t6_rst_end", pkt_end, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        t0 = cyc;
        n0 = npulse;
        push(32'd0, 32'hB00, 32'hB80);
        wait_pkt(32'd1, 60, "t6_count");
        chk("t6_latency", 32'(pulse_cyc), 32'(t0 + 3));
        chk("t6_begin", pulse_beg[n0], 32'hB00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
